// File: rtl/oclib_pkg.sv
// Shared codebase types: byte-channel structs and boolean parameter constants.
package oclib_pkg;

  localparam bit True  = 1'b1;
  localparam bit False = 1'b0;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } bc_8b_s;

  typedef struct packed {
    logic ready;
  } bc_8b_fb_s;

endpackage

// File: rtl/oclib_rr_arbiter.sv
// Combinational round-robin pick: search starts one past the pointer and wraps.
module oclib_rr_arbiter #(
  parameter  int Requesters = 4,
  localparam int GrantW     = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic [Requesters-1:0] req_i,
  input  logic [GrantW-1:0]     ptr_i,
  output logic                  gnt_valid_o,
  output logic [GrantW-1:0]     gnt_idx_o
);

  int                cand;
  logic [GrantW-1:0] idx;

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    cand        = 0;
    idx         = '0;
    // Offset 1..Requesters so the pointer owner is considered last.
    for (int i = 1; i <= Requesters; i++) begin
      cand = (int'(ptr_i) + i) % Requesters;
      idx  = GrantW'(cand);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = idx;
      end
    end
  end

endmodule

// File: rtl/oclib_bc_word_arbiter.sv
// Round-robin arbiter serializing word requests onto one byte channel as
// framed messages: [length] [source id] [data bytes, MSB first].
module oclib_bc_word_arbiter
  import oclib_pkg::*;
#(
  parameter  int Requesters   = 4,
  parameter  int WordWidth    = 64,
  parameter  bit PrefixLength = oclib_pkg::True,
  localparam int GrantW       = (Requesters > 1) ? $clog2(Requesters) : 1
) (
  input  logic                                 clock,
  input  logic                                 resetN,
  input  logic [Requesters-1:0][WordWidth-1:0] wordData,
  input  logic [Requesters-1:0]                wordValid,
  output logic [Requesters-1:0]                wordReady,
  output bc_8b_s                               bc,
  input  bc_8b_fb_s                            bcFb,
  output logic [GrantW-1:0]                    grantId,
  output logic                                 busy
);

  localparam int          WordBytes    = (WordWidth + 7) / 8;
  localparam int          ByteCounterW = (WordBytes > 1) ? $clog2(WordBytes) : 1;
  localparam logic [7:0]  LenByte      = 8'(WordBytes + 2);

  if (WordBytes + 2 > 255) begin : g_len_check
    $error("oclib_bc_word_arbiter: WordBytes+2 exceeds 255");
  end
  if (Requesters < 1 || Requesters > 255) begin : g_req_check
    $error("oclib_bc_word_arbiter: Requesters must be 1..255");
  end

  typedef enum logic [1:0] {StIdle, StLen, StId, StData} state_e;

  state_e                         state_q, state_d;
  logic [GrantW-1:0]              ptr_q, ptr_d;
  logic [WordBytes-1:0][7:0]      shreg_q, shreg_d;
  logic [ByteCounterW-1:0]        cnt_q, cnt_d, nxt_cnt;
  bc_8b_s                         bc_q, bc_d;
  logic [Requesters-1:0]          ready_q, ready_d;
  logic [GrantW-1:0]              gid_q, gid_d;
  logic                           busy_q, busy_d;
  logic [WordBytes*8-1:0]         padded;

  logic [Requesters-1:0]          eligible;
  logic                           gnt_vld;
  logic [GrantW-1:0]              gnt_idx;
  logic                           capture, accept, last_byte;

  // A requester being acknowledged this cycle still shows its old valid.
  assign eligible = wordValid & ~ready_q;

  oclib_rr_arbiter #(.Requesters(Requesters)) u_rr (
    .req_i       (eligible),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_vld),
    .gnt_idx_o   (gnt_idx)
  );

  assign capture   = (state_q == StIdle) && gnt_vld;
  assign accept    = bc_q.valid && bcFb.ready;
  assign last_byte = (cnt_q == ByteCounterW'(WordBytes - 1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (capture) state_d = PrefixLength ? StLen : StId;
      StLen:   if (accept) state_d = StId;
      StId:    if (accept) state_d = StData;
      StData:  if (accept && last_byte) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs: each state loads the byte that
  // follows the one currently on the channel once it is accepted.
  always_comb begin
    ptr_d   = ptr_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bc_d    = bc_q;
    ready_d = '0;
    gid_d   = gid_q;
    busy_d  = busy_q;
    padded  = (WordBytes*8)'(wordData[gnt_idx]);
    nxt_cnt = cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (capture) begin
          for (int b = 0; b < WordBytes; b++) begin
            shreg_d[b] = padded[(WordBytes-1-b)*8 +: 8];
          end
          ptr_d            = gnt_idx;
          gid_d            = gnt_idx;
          ready_d[gnt_idx] = 1'b1;
          busy_d           = 1'b1;
          cnt_d            = '0;
          bc_d.valid       = 1'b1;
          bc_d.data        = PrefixLength ? LenByte : 8'(gnt_idx);
        end
      end
      StLen: begin
        if (accept) bc_d.data = 8'(gid_q);
      end
      StId: begin
        if (accept) begin
          bc_d.data = shreg_q[0];
          cnt_d     = '0;
        end
      end
      StData: begin
        if (accept) begin
          if (last_byte) begin
            bc_d.valid = 1'b0;
            busy_d     = 1'b0;
          end else begin
            cnt_d     = nxt_cnt;
            bc_d.data = shreg_q[nxt_cnt];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      ptr_q   <= GrantW'(Requesters - 1);
      shreg_q <= '0;
      cnt_q   <= '0;
      bc_q    <= '0;
      ready_q <= '0;
      gid_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      bc_q    <= bc_d;
      ready_q <= ready_d;
      gid_q   <= gid_d;
      busy_q  <= busy_d;
    end
  end

  assign wordReady = ready_q;
  assign bc        = bc_q;
  assign grantId   = gid_q;
  assign busy      = busy_q;

endmodule

// File: doc/oclib_bc_word_arbiter.md
# oclib_bc_word_arbiter

Round-robin arbiter that shares one outbound byte channel (bc_8b) among several word-wide requesters. Each granted word is latched, acknowledged, and serialized as a framed message: length byte, source-ID byte, then data bytes MSB first. It sits between multiple on-chip word producers (status/telemetry blocks) and a single byte-serial management link.

## Interface
- Requesters, 4, number of word requesters (1..255).
- WordWidth, 64, bits per requester word. WordBytes = ceil(WordWidth/8).
- PrefixLength, oclib_pkg::True, emit length byte when set.

- clock  input  1  sole clock
- resetN  input  1  asynchronous, active-low reset
- wordData  input  Requesters x WordWidth  per-requester word; element i belongs to requester i
- wordValid  input  Requesters  per-requester request
- wordReady  output  Requesters  one-cycle capture pulse to the granted requester
- bc  output  oclib_pkg::bc_8b_s  byte channel (data, valid)
- bcFb  input  oclib_pkg::bc_8b_fb_s  byte channel feedback (ready)
- grantId  output  GrantW = max(1, clog2(Requesters))  index of the requester owning the current message
- busy  output  1  high from capture until the last byte is accepted

## Operation
- Reset values: bc.valid=0, bc.data=0, wordReady=0, grantId=0, busy=0, state=StIdle, priority pointer = Requesters-1, so requester 0 wins first.
- Frame: [WordBytes+2 if PrefixLength] [grantId zero-extended to 8 bits] [byte 0 .. byte WordBytes-1]. Byte 0 holds the MSBs. The word is zero-extended to WordBytes*8 before splitting.
- The length byte counts itself, the ID byte and the data bytes. WordBytes+2 must be 255 or less; flag an elaboration error otherwise.
- Arbitration: round-robin starting at pointer+1 with wrap. The pointer updates to the winner on capture only.
- wordValid is ignored on any requester whose wordReady is high in the same cycle.
- Requesters must hold wordData stable while wordValid is high and not yet acknowledged.
- State machine:
  - StIdle: if any eligible wordValid, capture the winner's word into the shift register, set grantId, pulse wordReady[winner] next cycle, set busy, and go to StLen (or StId if !PrefixLength).
  - StLen: present the length byte; on accept, go to StId.
  - StId: present the ID byte; on accept, go to StData with the byte counter at 0.
  - StData: present data byte[counter]; on accept, increment. On accepting byte WordBytes-1, drop bc.valid and busy, return to StIdle.
- Accept means bc.valid && bcFb.ready at a clock edge. bc.data is stable while bc.valid && !bcFb.ready.
- A request withdrawn before capture is simply not granted; there is no partial state.
- Assertion of resetN mid-frame aborts the frame immediately. No further bytes are sent, and the pointer returns to its reset value.

## Timing
- Every output is registered.
- Capture edge E0: wordReady and bc.valid (first frame byte) are high in cycle E0+1.
- With bcFb.ready held high, the frame takes WordBytes+2 consecutive cycles (WordBytes+1 without prefix), with no bubbles between bytes.
- There is exactly one idle cycle after the last accept before the next capture. Back-to-back frames occur every WordBytes+3 cycles.
- Backpressure: each cycle with bcFb.ready low stalls the frame by one cycle and holds bc.data.
- bcFb.ready asserted while bc.valid is low is ignored.
- resetN deasserts asynchronously into registers; synchronize resetN release externally or with the codebase reset module.

## Structure
- No new package types: reuse bc_8b_s / bc_8b_fb_s from oclib_pkg. Local constants are WordBytes, GrantW and ByteCounterW = max(1, clog2(WordBytes)).
- Sub-module oclib_rr_arbiter (parameter Requesters): combinational round-robin pick from a request vector and a pointer, with outputs grant valid and grant index. The pointer register lives in the parent.
- Datapath: a WordBytes x 8 capture register indexed by the byte counter, with the output byte registered into bc.data.

## Test plan
- Single request: Requesters=4, WordWidth=64, wordValid[2], wordData[2]=0x0102030405060708, ready high. Expect wordReady[2] pulse at E0+1 and bytes 0x0A,0x02,0x01..0x08 on consecutive cycles. Expect grantId=2.
- Fairness: all four valid continuously. Expect grant order 0,1,2,3,0,… with frames WordBytes+3 cycles apart.
- Backpressure: bcFb.ready toggles 1,0,0,1,… Expect each byte held stable until accepted, with no byte lost or duplicated.
- Odd width: WordWidth=12, data 0xABC. Expect frame 0x04, id, 0x0A, 0xBC. With PrefixLength=False, expect id, 0x0A, 0xBC.
- Reset mid-frame: drive resetN low after the third byte is accepted. Expect bc.valid to fall asynchronously. After release, requester 0 is granted first.
- Withdrawn request: pulse wordValid[1] low before it is granted while requester 3 is valid. Expect only requester 3 to be served and no wordReady[1].
